// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: pipeline-side request/stall/stack-push signals of the interrupt controller
interface interrupt_controller_if;
  logic        int_req;
  logic        mem_busy;
  logic        rti_done;
  logic        stall_fetch;
  logic        flush_fd;
  logic        push_en;
  logic        push_sel;
  logic        vec_rd;
  logic [15:0] vec_addr;
  logic        pc_load;
  logic        ack;
  logic        in_isr;
  modport master (
    input  int_req, mem_busy, rti_done,
    output stall_fetch, flush_fd, push_en, push_sel, vec_rd, vec_addr, pc_load, ack, in_isr
  );
  modport slave (
    output int_req, mem_busy, rti_done,
    input  stall_fetch, flush_fd, push_en, push_sel, vec_rd, vec_addr, pc_load, ack, in_isr
  );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: drains the pipeline, pushes PC and flags, fetches the ISR vector and jumps, one level deep
module interrupt_controller #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] VEC_ADDR     = 16'h0000
) (
  input logic clk,
  input logic reset,
  interrupt_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR, LOAD} state_t;
  state_t     state, nxt;
  logic [3:0] cnt, cnt_n;
  logic       int_q, pending, rise, isr;
  logic       stall, flush, sel, push_ph, vec_ph, load;
  assign rise = bus.int_req & ~int_q;
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    case (state)
      IDLE: if ((pending | rise) & ~isr) begin
        nxt   = DRAIN;
        cnt_n = 4'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        cnt_n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        nxt   = (cnt == 4'd0) ? PUSH_PC : DRAIN;
      end
      PUSH_PC:    nxt = bus.mem_busy ? PUSH_PC : PUSH_FLAGS;
      PUSH_FLAGS: nxt = bus.mem_busy ? PUSH_FLAGS : VECTOR;
      VECTOR:     nxt = bus.mem_busy ? VECTOR : LOAD;
      default:    nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      int_q   <= 1'b0;
      pending <= 1'b0;
      isr     <= 1'b0;
      stall   <= 1'b0;
      flush   <= 1'b0;
      sel     <= 1'b0;
      push_ph <= 1'b0;
      vec_ph  <= 1'b0;
      load    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      int_q   <= bus.int_req;
      pending <= rise | (pending & (state != LOAD));
      isr     <= (state == LOAD) | (isr & ~((state == IDLE) & bus.rti_done));
      stall   <= nxt != IDLE;
      flush   <= (state == IDLE) & (nxt == DRAIN);
      sel     <= nxt == PUSH_FLAGS;
      push_ph <= (nxt == PUSH_PC) | (nxt == PUSH_FLAGS);
      vec_ph  <= nxt == VECTOR;
      load    <= nxt == LOAD;
    end
  end
  assign bus.stall_fetch = stall;
  assign bus.flush_fd    = flush;
  assign bus.push_en     = push_ph & ~bus.mem_busy;
  assign bus.push_sel    = sel;
  assign bus.vec_rd      = vec_ph & ~bus.mem_busy;
  assign bus.vec_addr    = VEC_ADDR;
  assign bus.pc_load     = load;
  assign bus.ack         = load;
  assign bus.in_isr      = isr;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: per-cycle scoreboard of expected output vectors for the interrupt controller
module tb_interrupt_controller;
  localparam logic [15:0] VA = 16'h0040;
  // {stall_fetch, flush_fd, push_en, push_sel, vec_rd, pc_load, ack, in_isr}
  localparam logic [7:0] I0 = 8'h00, II = 8'h01, D1 = 8'hC0, DD = 8'h80, PP = 8'hA0, PB = 8'h80,
                         PF = 8'hB0, VV = 8'h88, LD = 8'h86;
  logic clk = 1'b0, reset = 1'b1;
  int n_chk = 0, n_pass = 0, n_cyc = 0, n_ack = 0;
  logic [7:0] exp_q[$];
  interrupt_controller_if bus ();
  interrupt_controller #(.DRAIN_CYCLES(3), .VEC_ADDR(VA)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic cyc(input logic r, input logic i, input logic b, input logic rti, input logic [7:0] exp);
    logic [7:0] e;
    reset = r;
    bus.int_req = i;
    bus.mem_busy = b;
    bus.rti_done = rti;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check($sformatf("c%0d", n_cyc), {8'h00, bus.stall_fetch, bus.flush_fd, bus.push_en, bus.push_sel,
          bus.vec_rd, bus.pc_load, bus.ack, bus.in_isr}, {8'h00, e});
    if (bus.ack) n_ack++;
    n_cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic run_seq(input logic i);
    cyc(0, i, 0, 0, D1);
    cyc(0, i, 0, 0, DD);
    cyc(0, i, 0, 0, DD);
    cyc(0, i, 0, 0, PP);
    cyc(0, i, 0, 0, PF);
    cyc(0, i, 0, 0, VV);
    cyc(0, i, 0, 0, LD);
  endtask
  initial begin
    bus.int_req = 1'b0;
    bus.mem_busy = 1'b0;
    bus.rti_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("vec_addr", bus.vec_addr, VA);
    cyc(1, 0, 0, 0, I0);
    // single event
    cyc(0, 1, 0, 0, I0);
    run_seq(0);
    cyc(0, 0, 0, 0, II);
    // no nesting: rise while in ISR is held pending until RTI
    cyc(0, 1, 0, 0, II);
    cyc(0, 0, 0, 0, II);
    cyc(0, 0, 0, 0, II);
    cyc(0, 0, 0, 1, II);
    cyc(0, 0, 0, 0, I0);
    run_seq(0);
    cyc(0, 0, 0, 1, II);
    cyc(0, 0, 0, 0, I0);
    // memory contention in PUSH_PC
    cyc(0, 1, 0, 0, I0);
    cyc(0, 0, 0, 0, D1);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 1, 0, PB);
    cyc(0, 0, 1, 0, PB);
    cyc(0, 0, 0, 0, PP);
    cyc(0, 0, 0, 0, PF);
    cyc(0, 0, 0, 0, VV);
    cyc(0, 0, 0, 0, LD);
    cyc(0, 0, 0, 1, II);
    cyc(0, 0, 0, 0, I0);
    // reset during PUSH_FLAGS loses the interrupt
    cyc(0, 1, 0, 0, I0);
    cyc(0, 0, 0, 0, D1);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 0, 0, PP);
    cyc(1, 0, 0, 0, PF);
    repeat (6) cyc(0, 0, 0, 0, I0);
    // held request: one event only
    cyc(0, 1, 0, 0, I0);
    run_seq(1);
    repeat (12) cyc(0, 1, 0, 0, II);
    cyc(0, 1, 0, 1, II);
    repeat (4) cyc(0, 1, 0, 0, I0);
    cyc(0, 0, 0, 0, I0);
    // rise in the LOAD cycle
    cyc(0, 1, 0, 0, I0);
    cyc(0, 0, 0, 0, D1);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 0, 0, DD);
    cyc(0, 0, 0, 0, PP);
    cyc(0, 0, 0, 0, PF);
    cyc(0, 0, 0, 0, VV);
    cyc(0, 1, 0, 0, LD);
    repeat (3) cyc(0, 0, 0, 0, II);
    cyc(0, 0, 0, 1, II);
    cyc(0, 0, 0, 0, I0);
    run_seq(0);
    cyc(0, 0, 0, 0, II);
    // int high across reset release counts as a rise
    cyc(1, 1, 0, 0, II);
    cyc(0, 1, 0, 0, I0);
    run_seq(1);
    cyc(0, 1, 0, 0, II);
    check("ack_count", 16'(n_ack), 16'd7);
    check("vec_addr_end", bus.vec_addr, VA);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, sets the number of stall cycles that let in-flight instructions retire before context save; legal range 1..15.
REQ-002 Parameter VEC_ADDR, default 16'h0000, is the data-memory address holding the ISR start address.
REQ-003 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 reset, input, 1: synchronous, active-high reset.
REQ-005 int, input, 1: external interrupt request, level sampled each clk; only a 0->1 transition is an event.
REQ-006 mem_busy, input, 1: data-memory port is held by the instruction in the MEM stage this cycle.
REQ-007 rti_done, input, 1: an RTI instruction committed in WB this cycle.
REQ-008 stall_fetch, output, 1: freeze PC and the fetch/decode register.
REQ-009 flush_fd, output, 1: replace the fetch/decode register contents with a NOP.
REQ-010 push_en, output, 1: write the stack word selected by push_sel to memory at SP, and decrement SP.
REQ-011 push_sel, output, 1: 0 selects the return PC, 1 selects the flags.
REQ-012 vec_rd, output, 1: read data memory at vec_addr.
REQ-013 vec_addr, output, 16: constant VEC_ADDR.
REQ-014 pc_load, output, 1: load PC from the vector read data.
REQ-015 ack, output, 1: one-cycle interrupt acknowledge.
REQ-016 in_isr, output, 1: an ISR is executing.

Function
REQ-017 Edge detect uses a registered int_q; rise = int & ~int_q.
REQ-018 A rise sets the pending bit; pending clears in the LOAD cycle, except that a rise in that same cycle keeps it set.
REQ-019 FSM states are IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR and LOAD, encoded in a 3-bit register.
REQ-020 IDLE -> DRAIN when (pending | rise) & ~in_isr; the drain counter loads DRAIN_CYCLES-1.
REQ-021 DRAIN decrements the counter every cycle and goes to PUSH_PC in the cycle the counter equals 0.
REQ-022 flush_fd=1 only in the first DRAIN cycle (counter = DRAIN_CYCLES-1).
REQ-023 PUSH_PC: push_sel=0 and push_en=~mem_busy; advance to PUSH_FLAGS only when mem_busy=0, otherwise hold.
REQ-024 PUSH_FLAGS: push_sel=1 and push_en=~mem_busy; advance to VECTOR only when mem_busy=0.
REQ-025 VECTOR: vec_rd=~mem_busy; advance to LOAD only when mem_busy=0.
REQ-026 LOAD: pc_load=1 and ack=1 for exactly this one cycle, set in_isr, then go to IDLE.
REQ-027 stall_fetch=1 in every non-IDLE state and 0 in IDLE.
REQ-028 push_sel=0 outside the PUSH_FLAGS state.
REQ-029 in_isr clears on the edge after rti_done=1 while in IDLE.
REQ-030 A pending interrupt then starts DRAIN no earlier than the cycle after in_isr reads 0, so there is no nesting.
REQ-031 rti_done outside IDLE is ignored.
REQ-032 Minimum latency, with mem_busy=0, from the edge sampling the rise to ack is DRAIN_CYCLES+4 cycles; each mem_busy cycle in a PUSH or VECTOR state adds one cycle.
REQ-033 int held high produces exactly one event; re-arming requires int=0 for at least one cycle.

Reset
REQ-034 While reset=1 at a clk edge: state becomes IDLE, and the counter, pending, int_q and in_isr all clear.
REQ-035 All outputs except vec_addr are 0 in the cycle after reset is sampled, including reset asserted mid-sequence.
REQ-036 An interrupt interrupted by reset is lost; no ack is ever produced for it.
REQ-037 int held high when reset is released counts as one rise, because int_q resets to 0.

Verification
REQ-038 Single-event timing, DRAIN_CYCLES=3, mem_busy=0, int=1 for one cycle:
- flush_fd pulses 1 cycle after the sampling edge;
- stall_fetch is high for 7 cycles;
- push_en is high 2 cycles (push_sel 0 then 1);
- vec_rd is high 1 cycle;
- ack and pc_load are high together in the 7th cycle;
- in_isr=1 afterwards.
REQ-039 Memory contention: mem_busy=1 for the first 2 PUSH_PC cycles -> push_en stays 0 for those cycles, ack moves to the 9th cycle, and exactly 2 pushes still occur.
REQ-040 No nesting: a second rise while in_isr=1 gives no stall; after rti_done=1, in_isr drops next cycle, a full sequence follows, and a second ack occurs.
REQ-041 Reset mid-sequence: reset=1 during PUSH_FLAGS -> next cycle all outputs are 0 and state is IDLE; with int=0 afterwards, no ack ever appears.
REQ-042 Held request: int=1 for 20 cycles with rti_done never asserted -> exactly one ack; rti_done pulsed later with int still 1 -> no new sequence.
REQ-043 Rise in the LOAD cycle: pending stays 1, no drain while in_isr=1, and the sequence starts right after rti_done clears in_isr.
